mem_stage: RTL and testbench

//   MIPS pipeline MEM stage, directly downstream of the ALU. Uses alu_value as the data address
//   (or passes it through), performs word/half/byte loads and stores on an internal data RAM

---
 rtl/mem_stage_pkg.sv | 75 +++++++
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage_data_mem.sv | 30 +++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS MEM stage: size codes, FSM encodings, request payload
// and lane helpers. Optional feature macro: MEM_MISALIGN_TRAP_EN (used in mem_stage).
package mem_stage_pkg;

    localparam int unsigned DWIDTH   = 32;
    localparam int unsigned PC_WIDTH = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [DWIDTH-1:0]   alu_value;
        logic [DWIDTH-1:0]   data_rt;
        logic [PC_WIDTH-1:0] pc;
        logic                mem_read;
        logic                mem_write;
        logic [1:0]          size;
        logic                is_unsigned;
        logic [4:0]          rd_addr;
        logic                reg_write;
    } mem_req_t;

    // Size code 11 behaves as a word everywhere.
    function automatic logic [DWIDTH-1:0] align_addr(input logic [DWIDTH-1:0] addr,
                                                     input logic [1:0] size);
        case (size)
            SIZE_BYTE: return addr;
            SIZE_HALF: return {addr[DWIDTH-1:1], 1'b0};
            default:   return {addr[DWIDTH-1:2], 2'b00};
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 4'(4'b0001 << lane);
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] store_data(input logic [1:0] size,
                                                     input logic [DWIDTH-1:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] load_extend(input logic [DWIDTH-1:0] rdata,
                                                      input logic [1:0] lane,
                                                      input logic [1:0] size,
                                                      input logic is_unsigned);
        logic [DWIDTH-1:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: return is_unsigned ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return rdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ALU-to-MEM request and MEM-to-writeback result bundle.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                m_i_valid;
    logic [DWIDTH-1:0]   m_i_alu_value;
    logic [DWIDTH-1:0]   m_i_data_rt;
    logic [PC_WIDTH-1:0] m_i_pc;
    logic                m_i_mem_read;
    logic                m_i_mem_write;
    logic [1:0]          m_i_size;
    logic                m_i_unsigned;
    logic [4:0]          m_i_rd_addr;
    logic                m_i_reg_write;
    logic                m_i_flush;
    logic                m_o_stall;
    logic                m_o_valid;
    logic [DWIDTH-1:0]   m_o_wb_data;
    logic [4:0]          m_o_rd_addr;
    logic                m_o_reg_write;
    logic [PC_WIDTH-1:0] m_o_pc;
    logic                m_o_misalign;

    modport master (
        output m_i_valid, m_i_alu_value, m_i_data_rt, m_i_pc, m_i_mem_read, m_i_mem_write,
               m_i_size, m_i_unsigned, m_i_rd_addr, m_i_reg_write, m_i_flush,
        input  m_o_stall, m_o_valid, m_o_wb_data, m_o_rd_addr, m_o_reg_write, m_o_pc,
               m_o_misalign
    );

    modport slave (
        input  m_i_valid, m_i_alu_value, m_i_data_rt, m_i_pc, m_i_mem_read, m_i_mem_write,
               m_i_size, m_i_unsigned, m_i_rd_addr, m_i_reg_write, m_i_flush,
        output m_o_stall, m_o_valid, m_o_wb_data, m_o_rd_addr, m_o_reg_write, m_o_pc,
               m_o_misalign
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Synchronous single-port data RAM: per-byte write enables, registered read data
// that holds its value while the port is idle. Contents are never reset.
module data_mem #(
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [AWIDTH-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: IDLE/WAIT FSM with MEM_LAT wait states around an internal data RAM.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned AWIDTH  = 10,
    parameter int unsigned MEM_LAT = 2
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [0:0]          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    mem_req_t            req_q, req_nxt, in_req;
    logic [DWIDTH-1:0]   aligned_addr, addr_src, rdata, wdata;
    logic [3:0]          be;
    logic [AWIDTH-1:0]   ram_addr;
    logic                ram_en, ram_we, mem_op, trap;

    logic                valid_q, valid_nxt, regw_q, regw_nxt, mis_q, mis_nxt;
    logic [DWIDTH-1:0]   wb_q, wb_nxt;
    logic [4:0]          rd_q, rd_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;

    assign aligned_addr = align_addr(bus.m_i_alu_value, bus.m_i_size);
    assign mem_op       = bus.m_i_mem_read | bus.m_i_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op & is_misaligned(bus.m_i_size, bus.m_i_alu_value[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        in_req             = '0;
        in_req.alu_value   = aligned_addr;
        in_req.data_rt     = bus.m_i_data_rt;
        in_req.pc          = bus.m_i_pc;
        in_req.mem_read    = bus.m_i_mem_read;
        in_req.mem_write   = bus.m_i_mem_write;
        in_req.size        = bus.m_i_size;
        in_req.is_unsigned = bus.m_i_unsigned;
        in_req.rd_addr     = bus.m_i_rd_addr;
        in_req.reg_write   = bus.m_i_reg_write;
    end

    // Loads read the RAM on acceptance; the RAM holds the word until completion, so the
    // extended result can be registered straight into the output stage.
    assign addr_src = (state == ST_IDLE) ? aligned_addr : req_q.alu_value;
    assign ram_addr = addr_src[AWIDTH+1:2];
    assign be       = store_be(req_q.size, req_q.alu_value[1:0]);
    assign wdata    = store_data(req_q.size, req_q.data_rt);

    data_mem #(.AWIDTH(AWIDTH)) u_data_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (be),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            wb_q    <= '0;
            rd_q    <= '0;
            regw_q  <= 1'b0;
            pc_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            req_q   <= req_nxt;
            valid_q <= valid_nxt;
            wb_q    <= wb_nxt;
            rd_q    <= rd_nxt;
            regw_q  <= regw_nxt;
            pc_q    <= pc_nxt;
            mis_q   <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        valid_nxt = 1'b0;
        mis_nxt   = 1'b0;
        wb_nxt    = wb_q;
        rd_nxt    = rd_q;
        regw_nxt  = regw_q;
        pc_nxt    = pc_q;
        case (state)
            ST_IDLE: begin
                if (bus.m_i_valid && !bus.m_i_flush) begin
                    if (!mem_op || trap) begin
                        valid_nxt = 1'b1;
                        mis_nxt   = trap;
                        wb_nxt    = trap ? '0 : bus.m_i_alu_value;
                        rd_nxt    = bus.m_i_rd_addr;
                        regw_nxt  = trap ? 1'b0 : bus.m_i_reg_write;
                        pc_nxt    = bus.m_i_pc;
                    end else begin
                        req_nxt   = in_req;
                        cnt_nxt   = CNT_W'(MEM_LAT - 1);
                        state_nxt = ST_WAIT;
                        ram_en    = bus.m_i_mem_read;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b1;
                    rd_nxt    = req_q.rd_addr;
                    pc_nxt    = req_q.pc;
                    if (req_q.mem_write) begin
                        ram_en   = 1'b1;
                        ram_we   = 1'b1;
                        wb_nxt   = '0;
                        regw_nxt = 1'b0;
                    end else begin
                        wb_nxt   = load_extend(rdata, req_q.alu_value[1:0], req_q.size,
                                               req_q.is_unsigned);
                        regw_nxt = req_q.reg_write;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{addr_src[DWIDTH-1:AWIDTH+2], req_q.mem_read};

    assign bus.m_o_stall     = (state == ST_WAIT);
    assign bus.m_o_valid     = valid_q;
    assign bus.m_o_wb_data   = wb_q;
    assign bus.m_o_rd_addr   = rd_q;
    assign bus.m_o_reg_write = regw_q;
    assign bus.m_o_pc        = pc_q;
    assign bus.m_o_misalign  = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random traffic checked against
// a byte-array memory model.
module tb_mem_stage;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;
    localparam int unsigned NBYTES = 1 << (AW + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_stage_if bus();

    mem_stage #(.AWIDTH(AW), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] ref_mem [0:NBYTES-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.m_i_valid     = 1'b0;
        bus.m_i_alu_value = '0;
        bus.m_i_data_rt   = '0;
        bus.m_i_pc        = '0;
        bus.m_i_mem_read  = 1'b0;
        bus.m_i_mem_write = 1'b0;
        bus.m_i_size      = 2'b00;
        bus.m_i_unsigned  = 1'b0;
        bus.m_i_rd_addr   = '0;
        bus.m_i_reg_write = 1'b0;
        bus.m_i_flush     = 1'b0;
    endtask

    task automatic drive_op(input bit is_ld, input bit is_st, input logic [1:0] size,
                            input bit uns, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] rd, input bit regw, input logic [31:0] pc,
                            input bit flush);
        bus.m_i_valid     = 1'b1;
        bus.m_i_alu_value = addr;
        bus.m_i_data_rt   = data;
        bus.m_i_pc        = pc;
        bus.m_i_mem_read  = is_ld;
        bus.m_i_mem_write = is_st;
        bus.m_i_size      = size;
        bus.m_i_unsigned  = uns;
        bus.m_i_rd_addr   = rd;
        bus.m_i_reg_write = regw;
        bus.m_i_flush     = flush;
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Model: apply a store to the byte array, or build the expected load value.
    task automatic model_op(input bit is_ld, input bit is_st, input logic [1:0] size,
                            input bit uns, input logic [31:0] addr, input logic [31:0] data,
                            input bit regw, output logic [31:0] exp_wb, output bit exp_regw,
                            output bit exp_mis, output int exp_lat);
        int n, b;
        bit mis;
        logic [31:0] v;
        n   = size_bytes(size);
        mis = (int'(addr[1:0]) % n) != 0;
        b   = (int'(addr[AW+1:0]) / n) * n;
        exp_mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        exp_mis = (is_ld || is_st) && mis;
`endif
        if (exp_mis) begin
            exp_wb = 0; exp_regw = 0; exp_lat = 0;
        end else if (is_st) begin
            for (int i = 0; i < n; i++) ref_mem[b+i] = data[8*i +: 8];
            exp_wb = 0; exp_regw = 0; exp_lat = LAT;
        end else if (is_ld) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[b+i]) << (8*i));
            if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_wb = v; exp_regw = regw; exp_lat = LAT;
        end else begin
            exp_wb = addr; exp_regw = regw; exp_lat = 0;
        end
    endtask

    // Issue one op (at #1 after an edge), wait for its result and check every field.
    task automatic run_op(input string tag, input bit is_ld, input bit is_st,
                          input logic [1:0] size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input bit regw,
                          input logic [31:0] pc);
        logic [31:0] exp_wb;
        bit exp_regw, exp_mis;
        int exp_lat, lat, stalls;
        model_op(is_ld, is_st, size, uns, addr, data, regw, exp_wb, exp_regw, exp_mis, exp_lat);
        drive_op(is_ld, is_st, size, uns, addr, data, rd, regw, pc, 1'b0);
        check({tag, "_stall_idle"}, 32'(bus.m_o_stall), 0);
        @(posedge clk); #1;
        drive_idle();
        lat = 0; stalls = 0;
        while (!bus.m_o_valid && lat < 20) begin
            if (bus.m_o_stall) stalls++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_wb_data"}, bus.m_o_wb_data, exp_wb);
        check({tag, "_rd_addr"}, 32'(bus.m_o_rd_addr), 32'(rd));
        check({tag, "_reg_write"}, 32'(bus.m_o_reg_write), 32'(exp_regw));
        check({tag, "_pc"}, bus.m_o_pc, pc);
        check({tag, "_misalign"}, 32'(bus.m_o_misalign), 32'(exp_mis));
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, 32'(bus.m_o_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.m_o_valid), 0);
        check({tag, "_stall"}, 32'(bus.m_o_stall), 0);
        check({tag, "_wb"}, bus.m_o_wb_data, 0);
        check({tag, "_rd"}, 32'(bus.m_o_rd_addr), 0);
        check({tag, "_regw"}, 32'(bus.m_o_reg_write), 0);
        check({tag, "_pc"}, bus.m_o_pc, 0);
        check({tag, "_mis"}, 32'(bus.m_o_misalign), 0);
    endtask

    initial begin
        int lat, pulses;
        bit seen_stall;
        logic [31:0] a, d, ew;
        bit er, em;
        int el;
        int kind;

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Known contents for the low 64 bytes.
        for (int i = 0; i < 16; i++)
            run_op("preload", 0, 1, 2'b10, 0, 32'(4*i), $urandom(), 5'd0, 0, 32'h100 + 32'(4*i));

        run_op("nonmem", 0, 0, 2'b10, 0, 32'd9, 32'd0, 5'd3, 1, 32'h400);
        run_op("sw8", 0, 1, 2'b10, 0, 32'd8, 32'hDEADBEEF, 5'd4, 1, 32'h404);
        run_op("lw8", 1, 0, 2'b10, 0, 32'd8, 32'd0, 5'd5, 1, 32'h408);
        run_op("sb5", 0, 1, 2'b00, 0, 32'd5, 32'h12345680, 5'd6, 1, 32'h40C);
        run_op("lb5", 1, 0, 2'b00, 0, 32'd5, 32'd0, 5'd7, 1, 32'h410);
        run_op("lbu5", 1, 0, 2'b00, 1, 32'd5, 32'd0, 5'd8, 1, 32'h414);
        run_op("lw4", 1, 0, 2'b10, 0, 32'd4, 32'd0, 5'd9, 1, 32'h418);
        run_op("sw6", 0, 1, 2'b10, 0, 32'd6, 32'hCAFEF00D, 5'd10, 1, 32'h41C);
        run_op("lw6", 1, 0, 2'b10, 0, 32'd6, 32'd0, 5'd11, 1, 32'h420);
        run_op("lw4b", 1, 0, 2'b10, 0, 32'd4, 32'd0, 5'd12, 1, 32'h424);
        run_op("lh_hi", 1, 0, 2'b01, 0, 32'h0000_1002, 32'd0, 5'd13, 1, 32'h428);

        // Flushed store in IDLE: no stall, no result, RAM untouched.
        drive_op(0, 1, 2'b10, 0, 32'd28, 32'h55AA55AA, 5'd1, 0, 32'h500, 1);
        @(posedge clk); #1;
        drive_idle();
        seen_stall = 0; pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_o_stall) seen_stall = 1;
            if (bus.m_o_valid) pulses++;
            @(posedge clk); #1;
        end
        check("flush_idle_stall", 32'(seen_stall), 0);
        check("flush_idle_valid", 32'(pulses), 0);
        run_op("lw28", 1, 0, 2'b10, 0, 32'd28, 32'd0, 5'd2, 1, 32'h504);

        // Flush asserted while a store is in WAIT: the store still completes.
        model_op(0, 1, 2'b10, 0, 32'd20, 32'h0BADCAFE, 0, ew, er, em, el);
        drive_op(0, 1, 2'b10, 0, 32'd20, 32'h0BADCAFE, 5'd14, 1, 32'h600, 0);
        @(posedge clk); #1;
        drive_op(0, 1, 2'b10, 0, 32'd24, 32'h77777777, 5'd15, 0, 32'h604, 1);
        lat = 0;
        while (!bus.m_o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("flush_wait_latency", 32'(lat), 32'(LAT));
        check("flush_wait_pc", bus.m_o_pc, 32'h600);
        check("flush_wait_regw", 32'(bus.m_o_reg_write), 0);
        @(posedge clk); #1;
        drive_idle();
        check("flush_wait_no_2nd_valid", 32'(bus.m_o_valid), 0);
        check("flush_wait_no_stall", 32'(bus.m_o_stall), 0);
        run_op("lw20", 1, 0, 2'b10, 0, 32'd20, 32'd0, 5'd16, 1, 32'h608);
        run_op("lw24", 1, 0, 2'b10, 0, 32'd24, 32'd0, 5'd17, 1, 32'h60C);

        // Reset during WAIT of a store: outputs clear, store is dropped.
        drive_op(0, 1, 2'b10, 0, 32'd12, 32'h13579BDF, 5'd18, 1, 32'h700, 0);
        @(posedge clk); #1;
        drive_idle();
        check("rst_mid_stall_before", 32'(bus.m_o_stall), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.m_o_valid) pulses++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_valid", 32'(pulses), 0);
        run_op("lw12", 1, 0, 2'b10, 0, 32'd12, 32'd0, 5'd19, 1, 32'h704);

        // Random traffic inside the known region, with random high address bits.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            d = $urandom();
            run_op("rand", kind >= 2, kind == 1, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, d, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
